// File: rtl/conv33_pkg.sv
// Shared definitions for the 3x3 convolution sequencer: FSM encoding, kernel size
// and the tap-index helper used for both weight and window packing.
package conv33_pkg;

  localparam int KSIZE = 3;
  localparam int KTAPS = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_CALC   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_FIN    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_W = ST_LOAD_W,
    FETCH  = ST_FETCH,
    CALC   = ST_CALC,
    WAIT   = ST_WAIT,
    WRITE  = ST_WRITE,
    FIN    = ST_FIN
  } state_e;

  // Tap k = ky*3 + kx, matching the datapath's data_ky_kx / weight_k ordering.
  function automatic logic [3:0] tap_idx(input logic [1:0] ky, input logic [1:0] kx);
    return ({2'b00, ky} * 4'd3) + {2'b00, kx};
  endfunction

endpackage

// File: rtl/conv33_addr_gen.sv
// Pixel (r,c) and kernel tap (ky,kx) counters for the conv33 sequencer, producing
// feature-map read and output write addresses plus end-of-window/end-of-map flags.
module conv33_addr_gen
  import conv33_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  tap_run,
  input  logic                  pix_adv,
  output logic                  rd_fire,
  output logic                  last_tap,
  output logic [1:0]            ky,
  output logic [1:0]            kx,
  output logic [ADDR_WIDTH-1:0] fm_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  last_pixel
);

  localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] OUT_W_A = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(IMG_W - 3);
  localparam logic [ADDR_WIDTH-1:0] R_LAST  = ADDR_WIDTH'(IMG_H - 3);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_q, r_d, c_q, c_d;
  logic [1:0]            ky_q, ky_d, kx_q, kx_d;
  logic                  rd_done_q, rd_done_d;

  // Tap walk is ky-major; rd_done marks the extra capture-only cycle after tap 8.
  always_comb begin
    r_d       = r_q;
    c_d       = c_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    rd_done_d = rd_done_q;
    if (clr) begin
      r_d       = {ADDR_WIDTH{1'b0}};
      c_d       = {ADDR_WIDTH{1'b0}};
      ky_d      = 2'd0;
      kx_d      = 2'd0;
      rd_done_d = 1'b0;
    end else begin
      if (tap_run && rd_done_q) begin
        rd_done_d = 1'b0;
      end else if (tap_run && (kx_q == 2'd2)) begin
        kx_d = 2'd0;
        if (ky_q == 2'd2) begin
          ky_d      = 2'd0;
          rd_done_d = 1'b1;
        end else begin
          ky_d = ky_q + 2'd1;
        end
      end else if (tap_run) begin
        kx_d = kx_q + 2'd1;
      end else begin
        kx_d = kx_q;
      end
      if (pix_adv && (c_q == C_LAST)) begin
        c_d = {ADDR_WIDTH{1'b0}};
        r_d = r_q + ONE_A;
      end else if (pix_adv) begin
        c_d = c_q + ONE_A;
      end else begin
        c_d = c_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= {ADDR_WIDTH{1'b0}};
      c_q       <= {ADDR_WIDTH{1'b0}};
      ky_q      <= 2'd0;
      kx_q      <= 2'd0;
      rd_done_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      c_q       <= c_d;
      ky_q      <= ky_d;
      kx_q      <= kx_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign rd_fire    = tap_run & ~rd_done_q;
  assign last_tap   = rd_done_q;
  assign ky         = ky_q;
  assign kx         = kx_q;
  assign fm_addr    = ((r_q + ADDR_WIDTH'(ky_q)) * IMG_W_A) + c_q + ADDR_WIDTH'(kx_q);
  assign out_addr   = (r_q * OUT_W_A) + c_q;
  assign last_pixel = (r_q == R_LAST) && (c_q == C_LAST);

endmodule

// File: rtl/conv33_ctrl.sv
// Sequencer for one conv33_calc: loads 9 weights, then per valid-padding output pixel
// fetches the 3x3 window, pulses conv33_en, and writes the result with a ready handshake.
module conv33_ctrl
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   wt_base,
  output logic                    busy,
  output logic                    done,
  output logic                    wt_rd_en,
  output logic [ADDR_WIDTH-1:0]   wt_rd_addr,
  input  logic [DATA_WIDTH-1:0]   wt_rd_data,
  output logic                    fm_rd_en,
  output logic [ADDR_WIDTH-1:0]   fm_rd_addr,
  input  logic [DATA_WIDTH-1:0]   fm_rd_data,
  output logic [9*DATA_WIDTH-1:0] win_flat,
  output logic [9*DATA_WIDTH-1:0] weight_flat,
  output logic                    conv33_en,
  input  logic                    calc_valid,
  input  logic [DATA_WIDTH-1:0]   calc_result,
  output logic                    out_wr_en,
  output logic [ADDR_WIDTH-1:0]   out_wr_addr,
  output logic [DATA_WIDTH-1:0]   out_wr_data,
  input  logic                    out_wr_ready
);

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      wt_base_q, wt_base_d;
  logic [9*DATA_WIDTH-1:0]    win_q, win_d, weight_q, weight_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic                       cap_vld_q, cap_vld_d;
  logic [3:0]                 cap_idx_q, cap_idx_d;

  logic                       clr_s, tap_run_s, pix_adv_s, rd_fire_s, last_tap_s, last_pixel_s;
  logic [1:0]                 ky_s, kx_s;
  logic [ADDR_WIDTH-1:0]      fm_addr_s, out_addr_s;

  conv33_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_s),
    .tap_run    (tap_run_s),
    .pix_adv    (pix_adv_s),
    .rd_fire    (rd_fire_s),
    .last_tap   (last_tap_s),
    .ky         (ky_s),
    .kx         (kx_s),
    .fm_addr    (fm_addr_s),
    .out_addr   (out_addr_s),
    .last_pixel (last_pixel_s)
  );

  // Next state and capture; read data lands one cycle after its strobe, so the
  // tap index of each issued read is remembered in cap_idx_q for that capture.
  always_comb begin
    state_d    = state_q;
    wt_base_d  = wt_base_q;
    win_d      = win_q;
    weight_d   = weight_q;
    out_data_d = out_data_q;
    clr_s      = 1'b0;
    pix_adv_s  = 1'b0;
    tap_run_s  = (state_q == LOAD_W) || (state_q == FETCH);
    cap_vld_d  = rd_fire_s;
    cap_idx_d  = tap_idx(ky_s, kx_s);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_W;
          clr_s     = 1'b1;
          wt_base_d = wt_base;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_W: begin
        if (cap_vld_q) begin
          weight_d[int'(cap_idx_q)*DATA_WIDTH +: DATA_WIDTH] = wt_rd_data;
        end else begin
          weight_d = weight_q;
        end
        state_d = last_tap_s ? FETCH : LOAD_W;
      end
      FETCH: begin
        if (cap_vld_q) begin
          win_d[int'(cap_idx_q)*DATA_WIDTH +: DATA_WIDTH] = fm_rd_data;
        end else begin
          win_d = win_q;
        end
        state_d = last_tap_s ? CALC : FETCH;
      end
      CALC: state_d = WAIT;
      WAIT: begin
        if (calc_valid) begin
          out_data_d = calc_result;
          state_d    = WRITE;
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        if (out_wr_ready) begin
          pix_adv_s = 1'b1;
          state_d   = last_pixel_s ? FIN : FETCH;
        end else begin
          state_d = WRITE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wt_base_q  <= {ADDR_WIDTH{1'b0}};
      win_q      <= {(9*DATA_WIDTH){1'b0}};
      weight_q   <= {(9*DATA_WIDTH){1'b0}};
      out_data_q <= {DATA_WIDTH{1'b0}};
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      wt_base_q  <= wt_base_d;
      win_q      <= win_d;
      weight_q   <= weight_d;
      out_data_q <= out_data_d;
      cap_vld_q  <= cap_vld_d;
      cap_idx_q  <= cap_idx_d;
    end
  end

  // Outputs decode registered state only; addresses read as zero when their strobe is low.
  assign busy        = (state_q != IDLE) && (state_q != FIN);
  assign done        = (state_q == FIN);
  assign wt_rd_en    = (state_q == LOAD_W) && rd_fire_s;
  assign wt_rd_addr  = wt_rd_en ? (wt_base_q + ADDR_WIDTH'(tap_idx(ky_s, kx_s))) : {ADDR_WIDTH{1'b0}};
  assign fm_rd_en    = (state_q == FETCH) && rd_fire_s;
  assign fm_rd_addr  = fm_rd_en ? fm_addr_s : {ADDR_WIDTH{1'b0}};
  assign win_flat    = win_q;
  assign weight_flat = weight_q;
  assign conv33_en   = (state_q == CALC);
  assign out_wr_en   = (state_q == WRITE);
  assign out_wr_addr = out_wr_en ? out_addr_s : {ADDR_WIDTH{1'b0}};
  assign out_wr_data = out_data_q;

endmodule

// File: tb/tb_conv33_ctrl.sv
// Bench for conv33_ctrl: a 5x4 instance driven from a run table with random ready,
// stray calc_valid and start pokes, plus a 3x3 single-pixel instance.
module tb_conv33_ctrl;

  localparam int AWD = 5, AHT = 4, NPIX = (AWD - 2) * (AHT - 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fm_val(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd13 + 16'd7;
    return t[7:0];
  endfunction

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    logic [15:0] t;
    t = a + 16'd1;
    return t[7:0];
  endfunction

  function automatic logic [71:0] exp_win(input int w, input int r, input int c);
    logic [71:0] v;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        v[(ky*3+kx)*8 +: 8] = fm_val(16'((r + ky) * w + c + kx));
    return v;
  endfunction

  function automatic logic [71:0] exp_wgt(input logic [15:0] base);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = rom_val(base + 16'(k));
    return v;
  endfunction

  function automatic logic [7:0] exp_res(input int w, input int r, input int c, input logic [15:0] base);
    logic [71:0] wi, wg;
    logic [31:0] s;
    wi = exp_win(w, r, c);
    wg = exp_wgt(base);
    s = 32'd0;
    for (int k = 0; k < 9; k++) s = s + 32'(wi[k*8 +: 8]) * 32'(wg[k*8 +: 8]);
    return s[7:0];
  endfunction

  // ---------------- instance A: 5x4 ----------------
  logic        a_start, a_busy, a_done, a_wt_rd_en, a_fm_rd_en, a_en, a_cv, a_we, a_wr;
  logic [15:0] a_wt_base, a_wt_rd_addr, a_fm_rd_addr, a_wa;
  logic [7:0]  a_wt_rd_data, a_fm_rd_data, a_cr, a_wd;
  logic [71:0] a_win, a_wgt;

  conv33_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .IMG_W(AWD), .IMG_H(AHT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .wt_base(a_wt_base), .busy(a_busy), .done(a_done),
    .wt_rd_en(a_wt_rd_en), .wt_rd_addr(a_wt_rd_addr), .wt_rd_data(a_wt_rd_data),
    .fm_rd_en(a_fm_rd_en), .fm_rd_addr(a_fm_rd_addr), .fm_rd_data(a_fm_rd_data),
    .win_flat(a_win), .weight_flat(a_wgt), .conv33_en(a_en), .calc_valid(a_cv),
    .calc_result(a_cr), .out_wr_en(a_we), .out_wr_addr(a_wa), .out_wr_data(a_wd),
    .out_wr_ready(a_wr));

  int          calc_delay = 1, cv_cnt = 0, en_n = 0, en0 = 0, wt_n = 0, done_n = 0;
  bit          rand_ready = 1'b0, man_ready = 1'b1, stray_en = 1'b0;
  logic        rr_q = 1'b1, stray = 1'b0;
  logic [7:0]  res_q = 8'd0;
  logic [15:0] cur_base = 16'd0;
  logic [15:0] fm_q[$];
  logic [23:0] wr_q[$];
  int          en_t[$];

  assign a_wr = rand_ready ? rr_q : man_ready;
  assign a_cv = (cv_cnt == 1) || stray;
  assign a_cr = (cv_cnt == 1) ? res_q : 8'hA5;

  // Memories (1-cycle read latency, junk when not strobed) and datapath model.
  always @(posedge clk) begin
    a_wt_rd_data <= a_wt_rd_en ? rom_val(a_wt_rd_addr) : 8'hEE;
    a_fm_rd_data <= a_fm_rd_en ? fm_val(a_fm_rd_addr) : 8'hEE;
    if (a_en) begin
      cv_cnt <= calc_delay;
      res_q  <= exp_res(AWD, (en_n - en0 - 1) / (AWD - 2), (en_n - en0 - 1) % (AWD - 2), cur_base);
    end else if (cv_cnt > 0) begin
      cv_cnt <= cv_cnt - 1;
    end
  end

  always @(posedge clk) begin
    #2;
    rr_q  = ($urandom_range(0, 3) != 0);
    stray = stray_en && (a_fm_rd_en || a_wt_rd_en) && ($urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    if (a_fm_rd_en) fm_q.push_back(a_fm_rd_addr);
    if (a_wt_rd_en) wt_n <= wt_n + 1;
    if (a_en) begin
      chk("a_window", a_win, exp_win(AWD, (en_n - en0) / (AWD - 2), (en_n - en0) % (AWD - 2)));
      chk("a_weights", a_wgt, exp_wgt(cur_base));
      en_t.push_back(cyc);
      en_n <= en_n + 1;
    end
    if (a_we && a_wr) wr_q.push_back({a_wa, a_wd});
    if (a_done) done_n <= done_n + 1;
  end

  // ---------------- instance B: 3x3 ----------------
  logic        b_start, b_busy, b_done, b_wt_rd_en, b_fm_rd_en, b_en, b_cv, b_we, b_wr;
  logic [15:0] b_wt_base, b_wt_rd_addr, b_fm_rd_addr, b_wa;
  logic [7:0]  b_wt_rd_data, b_fm_rd_data, b_cr, b_wd;
  logic [71:0] b_win, b_wgt;
  int          b_en_n = 0;
  logic [15:0] fm_b[$];
  logic [23:0] wr_b[$];

  conv33_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .wt_base(b_wt_base), .busy(b_busy), .done(b_done),
    .wt_rd_en(b_wt_rd_en), .wt_rd_addr(b_wt_rd_addr), .wt_rd_data(b_wt_rd_data),
    .fm_rd_en(b_fm_rd_en), .fm_rd_addr(b_fm_rd_addr), .fm_rd_data(b_fm_rd_data),
    .win_flat(b_win), .weight_flat(b_wgt), .conv33_en(b_en), .calc_valid(b_cv),
    .calc_result(b_cr), .out_wr_en(b_we), .out_wr_addr(b_wa), .out_wr_data(b_wd),
    .out_wr_ready(b_wr));

  always @(posedge clk) begin
    b_wt_rd_data <= b_wt_rd_en ? rom_val(b_wt_rd_addr) : 8'hEE;
    b_fm_rd_data <= b_fm_rd_en ? fm_val(b_fm_rd_addr) : 8'hEE;
    b_cv         <= b_en;
  end

  always @(negedge clk) begin
    if (b_fm_rd_en) fm_b.push_back(b_fm_rd_addr);
    if (b_en) begin
      chk("b_window", b_win, exp_win(3, 0, 0));
      chk("b_weights_1_to_9", b_wgt, exp_wgt(16'd0));
      b_en_n <= b_en_n + 1;
    end
    if (b_we && b_wr) wr_b.push_back({b_wa, b_wd});
  end

  // ---------------- one full map on instance A ----------------
  task automatic run_a(input logic [15:0] base, input int delay, input bit rnd, input bit strayf,
                       input bit pokes, input bit bp, input int exp_nw, input logic [15:0] exp_last);
    int fm0, wr0, wt0, dn0, et0, f1, e1, bad, idx;
    bit got_done, bp_done;
    logic [23:0] hold;
    cur_base = base; calc_delay = delay; rand_ready = rnd; stray_en = strayf; man_ready = !bp;
    fm0 = fm_q.size(); wr0 = wr_q.size(); wt0 = wt_n; dn0 = done_n; et0 = en_t.size(); en0 = en_n;
    @(negedge clk); a_wt_base = base; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0; a_wt_base = 16'hFFFF;
    got_done = 1'b0; bp_done = 1'b0;
    for (int t = 0; t < 3000 && !got_done; t++) begin
      @(negedge clk);
      a_start = pokes && (t == 30);
      if (bp && !bp_done && a_we) begin
        hold = {a_wa, a_wd}; f1 = fm_q.size(); e1 = en_n;
        repeat (4) begin
          chk("bp_wr_en_held", a_we, 1'b1);
          chk("bp_addr_data_held", {a_wa, a_wd}, hold);
          @(negedge clk);
        end
        chk("bp_no_advance", {fm_q.size(), en_n}, {f1, e1});
        man_ready = 1'b1; bp_done = 1'b1;
      end
      if (a_done) begin
        got_done = 1'b1;
        a_start = pokes;
      end
    end
    chk("done_within_budget", got_done, 1'b1);
    @(negedge clk); a_start = 1'b0; stray_en = 1'b0; rand_ready = 1'b0; man_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("busy_low_after_done", a_busy, 1'b0);
    chk("one_done_per_start", done_n - dn0, 1);
    chk("weight_reads", wt_n - wt0, 9);
    chk("fm_read_count", fm_q.size() - fm0, 9 * NPIX);
    bad = 0; idx = fm0;
    for (int r = 0; r < AHT - 2; r++)
      for (int c = 0; c < AWD - 2; c++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            if (idx >= fm_q.size() || fm_q[idx] !== 16'((r + ky) * AWD + c + kx)) bad++;
            idx++;
          end
    chk("fm_read_addrs", bad, 0);
    chk("write_count", wr_q.size() - wr0, exp_nw);
    bad = 0;
    for (int p = 0; p < NPIX; p++)
      if (wr0 + p >= wr_q.size() ||
          wr_q[wr0+p] !== {16'(p), exp_res(AWD, p / (AWD - 2), p % (AWD - 2), base)}) bad++;
    chk("write_addr_data", bad, 0);
    if (wr_q.size() > wr0) chk("last_write_addr", wr_q[wr_q.size()-1][23:8], exp_last);
    if (!rnd && !bp) begin
      bad = 0;
      for (int i = et0 + 1; i < en_t.size(); i++)
        if (en_t[i] - en_t[i-1] != 12 + delay) bad++;
      chk("per_pixel_latency", bad, 0);
    end
  endtask

  typedef struct {
    logic [15:0] base;
    int          delay;
    bit          rnd;
    bit          strayf;
    bit          pokes;
    bit          bp;
    int          exp_nw;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vt[6];
  int   bad_b, dn_abort;
  bit   b_ok;

  initial begin
    vt[0] = '{16'd100, 1, 1'b0, 1'b0, 1'b0, 1'b0, 6, 16'd5};
    vt[1] = '{16'd200, 3, 1'b0, 1'b1, 1'b0, 1'b0, 6, 16'd5};
    vt[2] = '{16'($urandom_range(0, 1000)), 2, 1'b1, 1'b1, 1'b0, 1'b0, 6, 16'd5};
    vt[3] = '{16'd7, 1, 1'b0, 1'b0, 1'b1, 1'b0, 6, 16'd5};
    vt[4] = '{16'd50, 1, 1'b0, 1'b0, 1'b0, 1'b1, 6, 16'd5};
    vt[5] = '{16'($urandom_range(0, 4000)), $urandom_range(1, 4), 1'b1, 1'b1, 1'b1, 1'b0, 6, 16'd5};

    rst_n = 1'b0; a_start = 1'b0; a_wt_base = 16'd0;
    b_start = 1'b0; b_wt_base = 16'd0; b_wr = 1'b1; b_cr = exp_res(3, 0, 0, 16'd0);
    repeat (3) @(negedge clk);
    chk("reset_ctrl_outs", {a_busy, a_done, a_wt_rd_en, a_fm_rd_en, a_en, a_we}, 6'd0);
    chk("reset_addrs", {a_wt_rd_addr, a_fm_rd_addr, a_wa, a_wd}, 56'd0);
    chk("reset_win_wgt", {a_win, a_wgt}, 144'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single-pixel 3x3 map, weights 1..9 at ROM base 0
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    b_ok = 1'b0;
    for (int t = 0; t < 200 && !b_ok; t++) begin
      @(negedge clk);
      if (b_done) b_ok = 1'b1;
    end
    chk("b_done_within_budget", b_ok, 1'b1);
    chk("b_fm_read_count", fm_b.size(), 9);
    bad_b = 0;
    for (int i = 0; i < 9; i++) if (i >= fm_b.size() || fm_b[i] !== 16'(i)) bad_b++;
    chk("b_fm_addrs_0_8", bad_b, 0);
    chk("b_en_pulses", b_en_n, 1);
    chk("b_write_count", wr_b.size(), 1);
    if (wr_b.size() > 0) chk("b_write", wr_b[0], {16'd0, exp_res(3, 0, 0, 16'd0)});

    for (int i = 0; i < 6; i++)
      run_a(vt[i].base, vt[i].delay, vt[i].rnd, vt[i].strayf, vt[i].pokes, vt[i].bp,
            vt[i].exp_nw, vt[i].exp_last);

    // asynchronous reset in the middle of the first window fetch
    @(negedge clk); a_wt_base = 16'd40; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int t = 0; t < 50 && !a_fm_rd_en; t++) @(negedge clk);
    chk("reached_fetch", a_fm_rd_en, 1'b1);
    repeat (3) @(negedge clk);
    dn_abort = done_n;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl_outs", {a_busy, a_done, a_wt_rd_en, a_fm_rd_en, a_en, a_we}, 6'd0);
    chk("abort_addrs", {a_wt_rd_addr, a_fm_rd_addr, a_wa, a_wd}, 56'd0);
    chk("abort_win_wgt", {a_win, a_wgt}, 144'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_n - dn_abort, 0);
    chk("abort_idle", a_busy, 1'b0);
    run_a(16'd300, 1, 1'b0, 1'b0, 1'b0, 1'b0, 6, 16'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
